mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single 32-bit data memory port between the instruction fetch unit and the data memory controller. It captures the winning request into registers, drives a one-outstanding-transaction memory handshake, and returns read data and a one-cycle Ready pulse to the granted requester. An optional watchdog converts a missing memory acknowledge into a bus-error response.

## Interface
- FAIR, 1: 1 = round-robin when both requesters are pending; 0 = data always wins.
- TIMEOUT, 0: BUSY cycles without M_Ack before a bus error is raised; 0 disables the watchdog; 16-bit range.

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- I_Address  in  30  instruction word address
- I_ReadEnable  in  1  instruction read request, held until I_Ready
- I_Ready  out  1  one-cycle completion pulse to fetch
- I_ReadData  out  32  instruction read data
- I_BusErr  out  1  asserted with I_Ready on timeout
- D_Address  in  30  data word address
- D_WriteData  in  32  store data, already byte-lane aligned
- D_WriteEnable  in  4  byte write enables, bit 3 = bits 31:24
- D_ReadEnable  in  1  data read request
- D_Ready  out  1  one-cycle completion pulse to data controller
- D_ReadData  out  32  data read data
- D_BusErr  out  1  asserted with D_Ready on timeout
- M_Address  out  30  memory word address
- M_WriteData  out  32  memory write data
- M_WriteEnable  out  4  memory byte write enables
- M_ReadEnable  out  1  memory read strobe
- M_Ack  in  1  memory completion, one cycle
- M_ReadData  in  32  valid in the M_Ack cycle
- Busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE
  - BUSY_I, BUSY_D: transaction in flight
  - RESP_I, RESP_D: Ready cycle
- Request pending definitions:
  - Data request pending = D_ReadEnable | (D_WriteEnable != 0).
  - Instruction request pending = I_ReadEnable.
- IDLE arbitration:
  - Only one requester pending: grant it.
  - Both pending, FAIR=1: grant the one opposite to last_grant.
  - Both pending, FAIR=0: grant data.
  - On grant, last_grant is updated.
- Request capture on grant: address, write data and enables are registered. M_* outputs come from these registers only, and stay constant for the whole BUSY state.
- Data write (any D_WriteEnable bit set):
  - M_WriteEnable = D_WriteEnable and M_ReadEnable = 0.
  - A simultaneous D_ReadEnable is ignored; the write takes precedence.
- Data read: M_ReadEnable = 1 and M_WriteEnable = 0.
- Instruction read: M_ReadEnable = 1 and M_WriteEnable = 0.
- BUSY_x:
  - On M_Ack, M_ReadData is registered into x_ReadData. Writes leave x_ReadData unchanged.
  - The state then goes to RESP_x.
- Watchdog (TIMEOUT > 0):
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without M_Ack.
  - When the count reaches TIMEOUT, the state goes to RESP_x with x_BusErr set and x_ReadData = 0.
  - M_Ack in the same cycle as the timeout wins: normal completion, no error.
- RESP_x: x_Ready = 1 for exactly one cycle; all M strobes are 0. Next state is IDLE.
- x_ReadData holds until that requester's next completion.
- M_Ack is ignored in IDLE and RESP.

## Timing
- Reset values:
  - State IDLE; last_grant = I, so data wins the first contention.
  - All M_* outputs = 0.
  - I_Ready, D_Ready, I_BusErr, D_BusErr, Busy = 0.
  - I_ReadData, D_ReadData = 0; watchdog counter = 0.
- Reset mid-transaction: the transaction is abandoned; no Ready is issued; all outputs return to reset values on the next edge.
- Cycle sequence, with the request first seen in IDLE at cycle 0:
  - M strobes are valid from cycle 1.
  - M_Ack arrives at cycle k ≥ 1.
  - x_Ready and data are valid at cycle k+1.
  - IDLE is re-entered at cycle k+2.
- Minimum turnaround is 3 cycles per transaction.
- Requesters drop their request in the cycle after Ready. IDLE never sees a completed request as a new one.
- The loser of arbitration keeps its request asserted. It is granted in the IDLE cycle after the winner's RESP.
- Strobes deassert in RESP. There is no back-to-back strobe between transactions.
- Only one transaction is outstanding at a time.

## Test plan
- Instruction read only, FAIR=1: I_Address=0x0000100, memory acks 2 cycles after the strobe with 0x8C010004 → M_ReadEnable=1, M_Address=0x0000100 in cycles 1–3; I_Ready=1 with I_ReadData=0x8C010004 in cycle 4; D_Ready stays 0.
- Data byte write: D_WriteEnable=4'b0100, D_WriteData=0x5A5A5A5A, D_Address=0x0000040, ack in cycle 1 → M_WriteEnable=4'b0100, M_ReadEnable=0; D_Ready pulses in cycle 2; D_ReadData unchanged.
- Contention, FAIR=1, both requesting at cycle 0 after reset, both held → data granted first; instruction granted in the IDLE after D_Ready. A second simultaneous pair grants instruction first.
- Contention, FAIR=0, both requesting continuously for 3 rounds → data wins each time; instruction is granted only once data stops requesting.
- TIMEOUT=4, M_Ack never asserted → BUSY lasts 4 cycles; then x_Ready=1, x_BusErr=1, x_ReadData=0; the next transaction completes normally with BusErr=0.
- Reset asserted in BUSY_D → next cycle: state IDLE, all M strobes 0, no D_Ready pulse; a pending I_ReadEnable is granted 1 cycle after reset deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and the data controller.
// One transaction in flight; optional watchdog turns a lost M_Ack into a bus error.
module mem_port_arbiter #(
   parameter bit          FAIR    = 1'b1,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [29:0] I_Address,
   input  logic        I_ReadEnable,
   output logic        I_Ready,
   output logic [31:0] I_ReadData,
   output logic        I_BusErr,
   input  logic [29:0] D_Address,
   input  logic [31:0] D_WriteData,
   input  logic [3:0]  D_WriteEnable,
   input  logic        D_ReadEnable,
   output logic        D_Ready,
   output logic [31:0] D_ReadData,
   output logic        D_BusErr,
   output logic [29:0] M_Address,
   output logic [31:0] M_WriteData,
   output logic [3:0]  M_WriteEnable,
   output logic        M_ReadEnable,
   input  logic        M_Ack,
   input  logic [31:0] M_ReadData,
   output logic        Busy
);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   localparam logic [15:0] TIMEOUT_CYCLES = 16'(TIMEOUT);

   state_t      state;
   grant_t      last_grant;
   logic [15:0] wd_count;
   logic        i_pending;
   logic        d_pending;
   logic        pick_d;
   logic        wd_expired;

   always_comb begin
      i_pending = I_ReadEnable;
      d_pending = D_ReadEnable | (|D_WriteEnable);
      if (i_pending && d_pending)
         pick_d = !FAIR || (last_grant == GRANT_I);
      else
         pick_d = d_pending;
      // count holds completed idle BUSY cycles, so expiry fires on the TIMEOUT-th one
      wd_expired = (TIMEOUT_CYCLES != '0) && ((wd_count + 16'd1) == TIMEOUT_CYCLES);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= GRANT_I;
         wd_count      <= '0;
         M_Address     <= '0;
         M_WriteData   <= '0;
         M_WriteEnable <= '0;
         M_ReadEnable  <= 1'b0;
         I_Ready       <= 1'b0;
         D_Ready       <= 1'b0;
         I_BusErr      <= 1'b0;
         D_BusErr      <= 1'b0;
         I_ReadData    <= '0;
         D_ReadData    <= '0;
         Busy          <= 1'b0;
      end else begin
         I_Ready  <= 1'b0;
         D_Ready  <= 1'b0;
         I_BusErr <= 1'b0;
         D_BusErr <= 1'b0;
         case (state)
            IDLE: begin
               wd_count <= '0;
               if (pick_d) begin
                  state         <= BUSY_D;
                  last_grant    <= GRANT_D;
                  Busy          <= 1'b1;
                  M_Address     <= D_Address;
                  M_WriteData   <= D_WriteData;
                  M_WriteEnable <= D_WriteEnable;
                  M_ReadEnable  <= ~|D_WriteEnable;
               end else if (i_pending) begin
                  state         <= BUSY_I;
                  last_grant    <= GRANT_I;
                  Busy          <= 1'b1;
                  M_Address     <= I_Address;
                  M_WriteData   <= '0;
                  M_WriteEnable <= '0;
                  M_ReadEnable  <= 1'b1;
               end
            end
            BUSY_I, BUSY_D: begin
               if (M_Ack || wd_expired) begin
                  M_WriteEnable <= '0;
                  M_ReadEnable  <= 1'b0;
                  if (state == BUSY_I) begin
                     state      <= RESP_I;
                     I_Ready    <= 1'b1;
                     I_BusErr   <= !M_Ack;
                     I_ReadData <= M_Ack ? M_ReadData : '0;
                  end else begin
                     state    <= RESP_D;
                     D_Ready  <= 1'b1;
                     D_BusErr <= !M_Ack;
                     if (!M_Ack)
                        D_ReadData <= '0;
                     else if (M_ReadEnable)
                        D_ReadData <= M_ReadData;
                  end
               end else begin
                  wd_count <= wd_count + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut0 is fair with a 4-cycle watchdog, dut1 is data-priority
// without a watchdog; a transaction-level model is compared against both on every cycle.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   logic [29:0] i_addr[2];
   logic        i_re[2];
   logic        i_rdy[2];
   logic [31:0] i_rdata[2];
   logic        i_err[2];
   logic [29:0] d_addr[2];
   logic [31:0] d_wdata[2];
   logic [3:0]  d_we[2];
   logic        d_re[2];
   logic        d_rdy[2];
   logic [31:0] d_rdata[2];
   logic        d_err[2];
   logic [29:0] m_addr[2];
   logic [31:0] m_wdata[2];
   logic [3:0]  m_we[2];
   logic        m_re[2];
   logic        m_ack[2];
   logic [31:0] m_rdata[2];
   logic        busy[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(.FAIR(g == 0), .TIMEOUT((g == 0) ? 4 : 0)) dut (
         .clock(clk), .reset(rst),
         .I_Address(i_addr[g]), .I_ReadEnable(i_re[g]), .I_Ready(i_rdy[g]),
         .I_ReadData(i_rdata[g]), .I_BusErr(i_err[g]),
         .D_Address(d_addr[g]), .D_WriteData(d_wdata[g]), .D_WriteEnable(d_we[g]),
         .D_ReadEnable(d_re[g]), .D_Ready(d_rdy[g]), .D_ReadData(d_rdata[g]), .D_BusErr(d_err[g]),
         .M_Address(m_addr[g]), .M_WriteData(m_wdata[g]), .M_WriteEnable(m_we[g]),
         .M_ReadEnable(m_re[g]), .M_Ack(m_ack[g]), .M_ReadData(m_rdata[g]), .Busy(busy[g])
      );
   end

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, n, cyc, act, exp);
   endtask

   function automatic logic [31:0] mem_word(input logic [29:0] a);
      if (a == 30'h100) return 32'h8C01_0004;
      return {a, 2'b11} ^ 32'hF0F0_0000;
   endfunction

   function automatic bit fair_of(input int n);
      return n == 0;
   endfunction

   function automatic int timeout_of(input int n);
      return (n == 0) ? 4 : 0;
   endfunction

   // Memory responder and requester drop logic (bench stimulus side)
   int  ack_lat[2];
   int  scnt[2];
   bit  stray[2];
   bit  drop_i[2];
   bit  drop_d[2];
   int  d_rep[2];

   always @(posedge clk) begin
      cyc++;
      #1;
      for (int n = 0; n < 2; n++) begin
         if (drop_i[n]) begin i_re[n] = 1'b0; drop_i[n] = 1'b0; end
         if (drop_d[n]) begin
            drop_d[n] = 1'b0;
            if (d_rep[n] > 0) begin d_rep[n]--; d_addr[n] = d_addr[n] + 30'd2; end
            else begin d_re[n] = 1'b0; d_we[n] = '0; end
         end
         if (m_re[n] === 1'b1 || (m_we[n] !== 4'b0000 && !$isunknown(m_we[n]))) scnt[n]++;
         else scnt[n] = 0;
         m_ack[n] = (ack_lat[n] >= 0 && scnt[n] == ack_lat[n] + 1) || stray[n];
         stray[n] = 1'b0;
         m_rdata[n] = m_ack[n] ? mem_word(m_addr[n]) : 32'hDEAD_BEEF;
      end
   end

   // Transaction-level model: owner, cycles since grant, and the cycle at which it finished
   int          own[2];
   int          tk[2];
   int          fin[2];
   bit          merr[2];
   bit          lastd[2];
   bit          cre[2];
   bit          mv[2];
   logic [29:0] ca[2];
   logic [31:0] cw[2];
   logic [3:0]  cwe[2];
   logic [31:0] eir[2];
   logic [31:0] edr[2];
   int          i_rdy_cyc[2], d_rdy_cyc[2], i_rdy_cnt[2], d_rdy_cnt[2];
   logic [31:0] i_rdy_dat[2], d_rdy_dat[2];
   logic        i_rdy_err[2], d_rdy_err[2];
   bit          fl, rs, ip, dp, pd;

   always @(negedge clk) begin
      for (int n = 0; n < 2; n++) begin
         fl = own[n] != 0 && fin[n] < 0;
         rs = own[n] != 0 && fin[n] >= 0;
         if (mv[n]) begin
            chk("Busy", n, busy[n], own[n] != 0);
            chk("M_ReadEnable", n, m_re[n], fl && cre[n]);
            chk("M_WriteEnable", n, m_we[n], fl ? cwe[n] : 4'b0000);
            if (fl) chk("M_Address", n, m_addr[n], ca[n]);
            if (fl && cwe[n] != 0) chk("M_WriteData", n, m_wdata[n], cw[n]);
            chk("I_Ready", n, i_rdy[n], rs && own[n] == 1);
            chk("I_BusErr", n, i_err[n], rs && own[n] == 1 && merr[n]);
            chk("D_Ready", n, d_rdy[n], rs && own[n] == 2);
            chk("D_BusErr", n, d_err[n], rs && own[n] == 2 && merr[n]);
            chk("I_ReadData", n, i_rdata[n], eir[n]);
            chk("D_ReadData", n, d_rdata[n], edr[n]);
         end
         if (i_rdy[n] === 1'b1) begin
            i_rdy_cyc[n] = cyc; i_rdy_dat[n] = i_rdata[n]; i_rdy_err[n] = i_err[n];
            i_rdy_cnt[n]++; drop_i[n] = 1'b1;
         end
         if (d_rdy[n] === 1'b1) begin
            d_rdy_cyc[n] = cyc; d_rdy_dat[n] = d_rdata[n]; d_rdy_err[n] = d_err[n];
            d_rdy_cnt[n]++; drop_d[n] = 1'b1;
         end
         if (rst) begin
            own[n] = 0; lastd[n] = 1'b0; eir[n] = '0; edr[n] = '0; mv[n] = 1'b1;
         end else if (own[n] == 0) begin
            ip = i_re[n];
            dp = d_re[n] || d_we[n] != 0;
            if (ip && dp) pd = fair_of(n) ? !lastd[n] : 1'b1;
            else pd = dp;
            if (ip || dp) begin
               own[n] = pd ? 2 : 1; lastd[n] = pd; tk[n] = 1; fin[n] = -1;
               ca[n]  = pd ? d_addr[n] : i_addr[n];
               cw[n]  = d_wdata[n];
               cwe[n] = pd ? d_we[n] : 4'b0000;
               cre[n] = !pd || d_we[n] == 0;
            end
         end else if (fin[n] < 0) begin
            if (m_ack[n]) begin
               fin[n] = tk[n]; merr[n] = 1'b0;
               if (cre[n]) begin
                  if (own[n] == 1) eir[n] = m_rdata[n]; else edr[n] = m_rdata[n];
               end
            end else if (timeout_of(n) != 0 && tk[n] == timeout_of(n)) begin
               fin[n] = tk[n]; merr[n] = 1'b1;
               if (own[n] == 1) eir[n] = '0; else edr[n] = '0;
            end
            tk[n]++;
         end else begin
            own[n] = 0;
         end
      end
   end

   task automatic cycles(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic wait_quiet(input int n, input string name);
      for (int k = 0; k < 60; k++) begin
         if (!i_re[n] && !d_re[n] && d_we[n] == 0 && busy[n] === 1'b0) return;
         cycles(1);
      end
      n_total++;
      $display("FAIL %s dut%0d: not idle after 60 cycles, got busy=%b required idle", name, n, busy[n]);
   endtask

   int c0;
   int dcnt;

   initial begin
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         i_addr[n] = '0; i_re[n] = 1'b0; d_addr[n] = '0; d_wdata[n] = '0; d_we[n] = '0;
         d_re[n] = 1'b0; m_ack[n] = 1'b0; m_rdata[n] = '0; ack_lat[n] = 0; scnt[n] = 0;
         stray[n] = 1'b0; drop_i[n] = 1'b0; drop_d[n] = 1'b0; d_rep[n] = 0; mv[n] = 1'b0;
         own[n] = 0; tk[n] = 0; fin[n] = -1; merr[n] = 1'b0; lastd[n] = 1'b0; cre[n] = 1'b0;
         i_rdy_cyc[n] = -1; d_rdy_cyc[n] = -1; i_rdy_cnt[n] = 0; d_rdy_cnt[n] = 0;
      end
      cycles(3);
      rst = 1'b0;
      chk("reset Busy", 0, busy[0], 1'b0);
      chk("reset M_Address", 0, m_addr[0], 30'h0);
      chk("reset M_WriteData", 0, m_wdata[0], 32'h0);
      chk("reset I_ReadData", 0, i_rdata[0], 32'h0);

      // Fair contention right after reset: data first, instruction in the following IDLE
      ack_lat[0] = 0; c0 = cyc;
      d_addr[0] = 30'h40;  d_re[0] = 1'b1;
      i_addr[0] = 30'h104; i_re[0] = 1'b1;
      wait_quiet(0, "pair1");
      chk("pair1 D_Ready cycle", 0, d_rdy_cyc[0] - c0, 2);
      chk("pair1 I_Ready cycle", 0, i_rdy_cyc[0] - c0, 5);
      chk("pair1 D data", 0, d_rdy_dat[0], 32'hF0F0_0103);
      chk("pair1 I data", 0, i_rdy_dat[0], 32'hF0F0_0413);

      // Instruction read alone, ack two cycles after the strobe
      ack_lat[0] = 2; c0 = cyc; dcnt = d_rdy_cnt[0];
      i_addr[0] = 30'h100; i_re[0] = 1'b1;
      wait_quiet(0, "iread");
      chk("iread I_Ready cycle", 0, i_rdy_cyc[0] - c0, 4);
      chk("iread I data", 0, i_rdy_dat[0], 32'h8C01_0004);
      chk("iread no D_Ready", 0, d_rdy_cnt[0] - dcnt, 0);

      // Byte write with a simultaneous read request: the write wins
      ack_lat[0] = 0; c0 = cyc;
      d_addr[0] = 30'h40; d_wdata[0] = 32'h5A5A_5A5A; d_we[0] = 4'b0100; d_re[0] = 1'b1;
      cycles(1);
      chk("bwrite M_WriteEnable", 0, m_we[0], 4'b0100);
      chk("bwrite M_ReadEnable", 0, m_re[0], 1'b0);
      chk("bwrite M_WriteData", 0, m_wdata[0], 32'h5A5A_5A5A);
      wait_quiet(0, "bwrite");
      chk("bwrite D_Ready cycle", 0, d_rdy_cyc[0] - c0, 2);
      chk("bwrite D data kept", 0, d_rdy_dat[0], 32'hF0F0_0103);

      // Second fair pair after a data grant: instruction first
      ack_lat[0] = 1; c0 = cyc;
      d_addr[0] = 30'h44; d_re[0] = 1'b1;
      i_addr[0] = 30'h108; i_re[0] = 1'b1;
      wait_quiet(0, "pair2");
      chk("pair2 I_Ready cycle", 0, i_rdy_cyc[0] - c0, 3);
      chk("pair2 D_Ready cycle", 0, d_rdy_cyc[0] - c0, 7);
      chk("pair2 D data", 0, d_rdy_dat[0], 32'hF0F0_0113);

      // Stray acknowledge while idle must be ignored
      stray[0] = 1'b1;
      cycles(3);

      // Watchdog: no ack, then a normal transaction
      ack_lat[0] = -1; c0 = cyc;
      i_addr[0] = 30'h200; i_re[0] = 1'b1;
      wait_quiet(0, "timeout");
      chk("timeout I_Ready cycle", 0, i_rdy_cyc[0] - c0, 5);
      chk("timeout I_BusErr", 0, i_rdy_err[0], 1'b1);
      chk("timeout I data", 0, i_rdy_dat[0], 32'h0);
      ack_lat[0] = 1; c0 = cyc;
      i_addr[0] = 30'h100; i_re[0] = 1'b1;
      wait_quiet(0, "after timeout");
      chk("after timeout cycle", 0, i_rdy_cyc[0] - c0, 3);
      chk("after timeout BusErr", 0, i_rdy_err[0], 1'b0);
      chk("after timeout data", 0, i_rdy_dat[0], 32'h8C01_0004);

      // Reset while a data write is in flight, instruction pending
      ack_lat[0] = 8; c0 = cyc;
      d_addr[0] = 30'h50; d_wdata[0] = 32'h1122_3344; d_we[0] = 4'b1111;
      cycles(2);
      dcnt = d_rdy_cnt[0];
      i_addr[0] = 30'h100; i_re[0] = 1'b1;
      rst = 1'b1; d_we[0] = '0; ack_lat[0] = 1;
      cycles(1);
      rst = 1'b0;
      chk("rst-busy M_ReadEnable", 0, m_re[0], 1'b0);
      chk("rst-busy M_WriteEnable", 0, m_we[0], 4'b0000);
      chk("rst-busy Busy", 0, busy[0], 1'b0);
      cycles(1);
      chk("rst-busy I granted", 0, m_re[0], 1'b1);
      chk("rst-busy I address", 0, m_addr[0], 30'h100);
      wait_quiet(0, "rst-busy");
      chk("rst-busy no D_Ready", 0, d_rdy_cnt[0] - dcnt, 0);
      chk("rst-busy I data", 0, i_rdy_dat[0], 32'h8C01_0004);

      // Data priority: data re-requests for three rounds, instruction waits
      ack_lat[1] = 0; c0 = cyc; dcnt = d_rdy_cnt[1]; d_rep[1] = 2;
      d_addr[1] = 30'h0E; d_re[1] = 1'b1;
      i_addr[1] = 30'h20; i_re[1] = 1'b1;
      wait_quiet(1, "prio");
      chk("prio D count", 1, d_rdy_cnt[1] - dcnt, 3);
      chk("prio last D cycle", 1, d_rdy_cyc[1] - c0, 8);
      chk("prio I_Ready cycle", 1, i_rdy_cyc[1] - c0, 11);
      chk("prio last D data", 1, d_rdy_dat[1], 32'hF0F0_004B);
      chk("prio I data", 1, i_rdy_dat[1], 32'hF0F0_0083);

      cycles(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got simulation still running, required completion");
      $fatal(1, "bench did not complete");
   end

endmodule
